// File: rtl/t_down_counter_pkg.sv
// rtl/t_down_counter_pkg.sv - shared constants and types for the T flip-flop down counter
//
// Purpose: default counter width, FSM state encoding and Mode input encodings
//          shared by t_down_counter and its testbench.
// Contents:
//    T_DOWN_WIDTH  default counter width
//    state_t       IDLE=0, RUN=1
//    ONE_SHOT      Mode value that stops at terminal count
//    AUTO_RELOAD   Mode value that reloads at terminal count
package t_down_counter_pkg;

   localparam int T_DOWN_WIDTH = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic ONE_SHOT    = 1'b0;
   localparam logic AUTO_RELOAD = 1'b1;

endpackage

// File: rtl/t_down_counter_t_ff.sv
// rtl/t_down_counter_t_ff.sv - single T flip-flop with synchronous clear and load
//
// Purpose: one bit of the down counter. Priority per edge: Reset, load, toggle, hold.
// Ports:
//    CLK      clock, rising edge
//    Reset    synchronous active-high clear to 0
//    i_t      toggle enable
//    i_ld     synchronous load enable
//    i_ld_d   load data
//    o_q      registered bit value
module t_ff (
   input  logic CLK,
   input  logic Reset,
   input  logic i_t,
   input  logic i_ld,
   input  logic i_ld_d,
   output logic o_q
);

   logic r_q;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_q <= 1'b0;
      end else if (i_ld) begin
         r_q <= i_ld_d;
      end else if (i_t) begin
         r_q <= ~r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/t_down_counter.sv
// rtl/t_down_counter.sv - loadable down counter built from T flip-flops
//
// Purpose: loads a value, counts it down once per enabled cycle while in RUN,
//          pulses TC on the terminal decrement, then stops (one-shot) or
//          reloads the last loaded value (auto-reload).
// Ports:
//    CLK    clock, rising edge
//    Reset  synchronous active-high reset
//    Load   load D into the count and reload register
//    D      load value
//    En     count enable, only honoured in RUN
//    Mode   0 = one-shot, 1 = auto-reload (sampled at terminal decrement only)
//    Q      current count (registered)
//    Busy   high while in RUN
//    TC     registered one-cycle terminal-count pulse
module t_down_counter
   import t_down_counter_pkg::*;
#(
   parameter int WIDTH = T_DOWN_WIDTH
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   input  logic             En,
   input  logic             Mode,
   output logic [WIDTH-1:0] Q,
   output logic             Busy,
   output logic             TC
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_reload;
   logic             r_tc;

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_borrow;
   logic [WIDTH-1:0] w_t;
   logic             w_count;
   logic             w_term;
   logic             w_ld;
   logic [WIDTH-1:0] w_ld_d;

   assign w_count = (r_state == RUN) && En;
   assign w_term  = w_count && (w_q == WIDTH'(1));

   // Decrement by toggling: bit i flips when every lower bit is 0 (borrow ripple).
   assign w_borrow[0] = 1'b1;
   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_borrow
         assign w_borrow[gi] = w_borrow[gi-1] & ~w_q[gi-1];
      end
   endgenerate

   assign w_t = w_count ? w_borrow : '0;

   // One-shot terminal needs no load: toggling 1 gives 0. Auto-reload and an
   // explicit Load override the toggles; Load takes priority over reload data.
   assign w_ld   = Load || (w_term && (Mode == AUTO_RELOAD));
   assign w_ld_d = Load ? D : r_reload;

   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         t_ff u_t_ff (
            .CLK    (CLK),
            .Reset  (Reset),
            .i_t    (w_t[gi]),
            .i_ld   (w_ld),
            .i_ld_d (w_ld_d[gi]),
            .o_q    (w_q[gi])
         );
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (Load) begin
         w_state_nxt = (D != '0) ? RUN : IDLE;
      end else if (w_term && (Mode == ONE_SHOT)) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_reload <= '0;
         r_tc     <= 1'b0;
      end else begin
         if (Load) begin
            r_reload <= D;
         end
         // Load coinciding with terminal decrement suppresses the pulse.
         r_tc <= w_term && !Load;
      end
   end

   assign Q    = w_q;
   assign Busy = (r_state == RUN);
   assign TC   = r_tc;

endmodule
